hwpe_stream_zero_fault_monitor: RTL and testbench
=================================================

Name: hwpe_stream_zero_fault_monitor

Overview:
Collects the `fault_detected_o` outputs of up to NB_CH zero sinks in a zero-network-protected HWPE datapath. Provides a simple arm/trip/acknowledge controller around them:
- per-channel masking
- sticky per-channel fault flags
- a saturating fault-cycle counter with a programmable alarm threshold
- capture of the first faulting channel and its timestamp

It sits beside the HWPE streamer/engine and drives a single alarm line to the control slave or event unit.

Parameters:
NB_CH, 4, number of monitored fault inputs (1..32)
CNT_WIDTH, 8, width of fault-cycle counter and threshold
TS_WIDTH, 16, width of timestamp counter and captured timestamp
CH_WIDTH, $clog2(NB_CH) (min 1), derived; width of channel index

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous clear, highest priority after reset
enable_i  in  1  monitor enable
ch_mask_i  in  NB_CH  1 = channel ignored
threshold_i  in  CNT_WIDTH  alarm threshold; 0 treated as 1
fault_i  in  NB_CH  fault_detected_o from each zero sink
ack_i  in  1  alarm acknowledge
alarm_o  out  1  alarm, registered
state_o  out  2  00 DISABLED, 01 ARMED, 10 TRIPPED
fault_sticky_o  out  NB_CH  sticky per-channel fault flags
fault_cnt_o  out  CNT_WIDTH  faulting cycles since arm/ack, saturating
first_valid_o  out  1  first-fault capture valid
first_ch_o  out  CH_WIDTH  index of first faulting channel
first_ts_o  out  TS_WIDTH  timestamp of first fault

Behaviour:
- Reset: state DISABLED. All outputs 0, timestamp counter 0.
- Event definition:
  - ev = |(fault_i & ~ch_mask_i), evaluated only in ARMED and TRIPPED.
  - In DISABLED, fault_i is ignored entirely.
- Timestamp counter:
  - Increments by 1 each cycle in ARMED or TRIPPED.
  - Saturates at all-ones; no wrap.
  - Held in DISABLED.
  - Cleared to 0 on the DISABLED->ARMED transition.
- State machine:
  - DISABLED -> ARMED when enable_i=1.
  - ARMED -> TRIPPED when ev=1 and the post-increment count >= max(threshold_i,1). Transition takes effect the next cycle; alarm_o=1 from the same edge.
  - TRIPPED -> ARMED on ack_i=1. On that edge: alarm_o=0, fault_cnt_o=0. Sticky flags and first-fault capture are retained.
  - Any state -> DISABLED when enable_i=0. alarm_o=0; all other outputs held.
  - ack_i in ARMED or DISABLED has no effect.
- Counter:
  - Increments by exactly 1 per cycle with ev=1, regardless of how many channels fault.
  - Saturates at 2^CNT_WIDTH-1.
  - Keeps counting in TRIPPED.
- Sticky flags: fault_sticky_o[i] set when fault_i[i] & ~ch_mask_i[i] in ARMED/TRIPPED; cleared only by reset or clear_i.
- First-fault capture:
  - On the first ev cycle while first_valid_o=0: latch first_ch_o = lowest faulting unmasked index, first_ts_o = current timestamp (pre-increment), first_valid_o=1.
  - Later faults do not overwrite the capture.
- clear_i:
  - Zeroes counter, sticky flags, capture, timestamp and alarm_o.
  - Next state is ARMED if enable_i=1, else DISABLED.
  - Overrides ev and ack_i in the same cycle.
- Simultaneous ack_i and ev in TRIPPED:
  - Ack wins; counter goes to 0, not 1.
  - The ev cycle still sets sticky flags.
- Threshold changes take effect immediately, with no retroactive trip until the next ev.
- Mask changes take effect combinationally on the same cycle's ev.
- Async reset mid-operation returns everything to reset values on assertion.

Test Plan:
- Reset, enable_i=1, threshold 3, fault_i[2] pulsed at ts 5,9,12 -> first_ch_o=2, first_ts_o=5, fault_cnt_o=3, alarm_o=1 the cycle after third pulse, state_o=10.
- fault_i=4'b1010 same cycle with ch_mask_i=4'b0010 -> first_ch_o=3, sticky=4'b1000, counter +1 only.
- TRIPPED, ack_i=1 and fault_i[0]=1 same cycle -> state ARMED, alarm_o=0, fault_cnt_o=0, sticky[0]=1, capture unchanged.
- threshold 0, single fault_i[1] cycle -> alarm after 1 event. 300 consecutive fault cycles, CNT_WIDTH=8 -> fault_cnt_o=255.
- enable_i=0 while faults continue -> state DISABLED, counter/sticky frozen. clear_i with enable_i=1 -> all zero, state ARMED, ts restarts at 0.
- rst_ni asserted asynchronously mid-TRIPPED (between clock edges) -> outputs zero immediately, state DISABLED.

Source files
------------

// File: rtl/hwpe_stream_zero_fault_monitor.sv
// hwpe_stream_zero_fault_monitor
// Watches the fault_detected_o lines of the zero sinks in a zero-network
// protected HWPE datapath. It keeps sticky per-channel flags, counts faulting
// cycles with saturation, records the first faulting channel and when it
// happened, and raises a registered alarm once the count reaches a
// programmable threshold.
//
// Alarm handshake: alarm_o is a level. It stays high while the monitor is
// TRIPPED. A single-cycle ack_i pulse seen in TRIPPED re-arms the monitor and
// drops alarm_o on that same clock edge. ack_i is ignored in any other state.
module hwpe_stream_zero_fault_monitor #(
   parameter int NB_CH     = 4,
   parameter int CNT_WIDTH = 8,
   parameter int TS_WIDTH  = 16,
   parameter int CH_WIDTH  = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 enable_i,
   input  logic [NB_CH-1:0]     ch_mask_i,
   input  logic [CNT_WIDTH-1:0] threshold_i,
   input  logic [NB_CH-1:0]     fault_i,
   input  logic                 ack_i,
   output logic                 alarm_o,
   output logic [1:0]           state_o,
   output logic [NB_CH-1:0]     fault_sticky_o,
   output logic [CNT_WIDTH-1:0] fault_cnt_o,
   output logic                 first_valid_o,
   output logic [CH_WIDTH-1:0]  first_ch_o,
   output logic [TS_WIDTH-1:0]  first_ts_o
);

   typedef enum logic [1:0] {
      ST_DISABLED = 2'b00,
      ST_ARMED    = 2'b01,
      ST_TRIPPED  = 2'b10
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic                  r_alarm;
   logic [NB_CH-1:0]      r_sticky;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [TS_WIDTH-1:0]   r_ts;
   logic                  r_first_valid;
   logic [CH_WIDTH-1:0]   r_first_ch;
   logic [TS_WIDTH-1:0]   r_first_ts;

   logic                  w_active;
   logic [NB_CH-1:0]      w_ev_vec;
   logic                  w_ev;
   logic [CNT_WIDTH-1:0]  w_cnt_inc;
   logic [TS_WIDTH-1:0]   w_ts_inc;
   logic [CNT_WIDTH-1:0]  w_thr;
   logic                  w_reach;
   logic                  w_ack_taken;
   logic [CH_WIDTH-1:0]   w_first_ch;

   // Faults only count while armed or tripped; the mask applies in the same cycle.
   assign w_active    = (r_state == ST_ARMED) || (r_state == ST_TRIPPED);
   assign w_ev_vec    = fault_i & ~ch_mask_i & {NB_CH{w_active}};
   assign w_ev        = |w_ev_vec;

   // Saturating increments: both counters stick at all-ones instead of wrapping.
   assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
   assign w_ts_inc    = (r_ts  == '1) ? r_ts  : r_ts  + 1'b1;

   // A threshold of zero behaves like one, so the first event always trips.
   assign w_thr       = (threshold_i == '0) ? CNT_WIDTH'(1) : threshold_i;
   assign w_reach     = w_ev && (w_cnt_inc >= w_thr);
   assign w_ack_taken = (r_state == ST_TRIPPED) && ack_i;

   // Lowest-index unmasked faulting channel (scan from the top so index 0 wins).
   always_comb begin
      w_first_ch = '0;
      for (int i = NB_CH - 1; i >= 0; i--) begin
         if (w_ev_vec[i]) begin
            w_first_ch = CH_WIDTH'(i);
         end
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_DISABLED;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: clear first, then disable, then the per-state rules.
   always_comb begin
      w_state_next = r_state;
      if (clear_i) begin
         w_state_next = enable_i ? ST_ARMED : ST_DISABLED;
      end else if (!enable_i) begin
         w_state_next = ST_DISABLED;
      end else begin
         case (r_state)
            ST_DISABLED: w_state_next = ST_ARMED;
            ST_ARMED:    if (w_reach) w_state_next = ST_TRIPPED;
            ST_TRIPPED:  if (ack_i)   w_state_next = ST_ARMED;
            default:     w_state_next = ST_DISABLED;
         endcase
      end
   end

   // Alarm follows entry into TRIPPED on the same edge as the state change.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_alarm <= 1'b0;
      end else begin
         r_alarm <= (w_state_next == ST_TRIPPED);
      end
   end

   // Datapath: timestamp, fault counter, sticky flags and first-fault capture.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ts          <= '0;
         r_cnt         <= '0;
         r_sticky      <= '0;
         r_first_valid <= 1'b0;
         r_first_ch    <= '0;
         r_first_ts    <= '0;
      end else if (clear_i) begin
         r_ts          <= '0;
         r_cnt         <= '0;
         r_sticky      <= '0;
         r_first_valid <= 1'b0;
         r_first_ch    <= '0;
         r_first_ts    <= '0;
      end else if (enable_i) begin
         // Leaving DISABLED restarts time at zero; otherwise time runs on.
         if (r_state == ST_DISABLED) begin
            r_ts <= '0;
         end else begin
            r_ts <= w_ts_inc;
         end

         r_sticky <= r_sticky | w_ev_vec;

         if (w_ev && !r_first_valid) begin
            r_first_valid <= 1'b1;
            r_first_ch    <= w_first_ch;
            r_first_ts    <= r_ts;
         end

         // Acknowledge beats a coincident event: the count restarts at zero.
         if (w_ack_taken) begin
            r_cnt <= '0;
         end else if (w_ev) begin
            r_cnt <= w_cnt_inc;
         end
      end
   end

   assign alarm_o        = r_alarm;
   assign state_o        = r_state;
   assign fault_sticky_o = r_sticky;
   assign fault_cnt_o    = r_cnt;
   assign first_valid_o  = r_first_valid;
   assign first_ch_o     = r_first_ch;
   assign first_ts_o     = r_first_ts;

endmodule

// File: tb/tb_hwpe_stream_zero_fault_monitor.sv
// Testbench for hwpe_stream_zero_fault_monitor: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_hwpe_stream_zero_fault_monitor;

   localparam int NB_CH     = 4;
   localparam int CNT_WIDTH = 8;
   localparam int TS_WIDTH  = 10;
   localparam int CH_WIDTH  = 2;
   localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;
   localparam int TS_MAX    = (1 << TS_WIDTH) - 1;

   logic                 clk_i;
   logic                 rst_ni;
   logic                 clear_i;
   logic                 enable_i;
   logic [NB_CH-1:0]     ch_mask_i;
   logic [CNT_WIDTH-1:0] threshold_i;
   logic [NB_CH-1:0]     fault_i;
   logic                 ack_i;
   logic                 alarm_o;
   logic [1:0]           state_o;
   logic [NB_CH-1:0]     fault_sticky_o;
   logic [CNT_WIDTH-1:0] fault_cnt_o;
   logic                 first_valid_o;
   logic [CH_WIDTH-1:0]  first_ch_o;
   logic [TS_WIDTH-1:0]  first_ts_o;

   int n_checks;
   int n_errors;

   // Reference model state (state encoded as the output code: 0/1/2).
   int       m_state;
   int       m_cnt;
   int       m_ts;
   bit [3:0] m_sticky;
   bit       m_fv;
   int       m_fch;
   int       m_fts;

   hwpe_stream_zero_fault_monitor #(
      .NB_CH     (NB_CH),
      .CNT_WIDTH (CNT_WIDTH),
      .TS_WIDTH  (TS_WIDTH)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .enable_i       (enable_i),
      .ch_mask_i      (ch_mask_i),
      .threshold_i    (threshold_i),
      .fault_i        (fault_i),
      .ack_i          (ack_i),
      .alarm_o        (alarm_o),
      .state_o        (state_o),
      .fault_sticky_o (fault_sticky_o),
      .fault_cnt_o    (fault_cnt_o),
      .first_valid_o  (first_valid_o),
      .first_ch_o     (first_ch_o),
      .first_ts_o     (first_ts_o)
   );

   // Clock generation.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Single comparison point: counts and reports.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state  = 0;
      m_cnt    = 0;
      m_ts     = 0;
      m_sticky = '0;
      m_fv     = 1'b0;
      m_fch    = 0;
      m_fts    = 0;
   endtask

   function automatic int sat_add1(input int v, input int max_v);
      return (v + 1 > max_v) ? max_v : v + 1;
   endfunction

   // Advance the model across one clock edge using the inputs currently driven.
   task automatic model_step();
      bit [3:0] evv;
      int       ts_pre;
      int       thr_eff;
      if (clear_i) begin
         model_reset();
         m_state = enable_i ? 1 : 0;
         return;
      end
      if (!enable_i) begin
         m_state = 0;
         return;
      end
      if (m_state == 0) begin
         m_state = 1;
         m_ts    = 0;
         return;
      end
      evv      = fault_i & ~ch_mask_i;
      ts_pre   = m_ts;
      m_ts     = sat_add1(m_ts, TS_MAX);
      m_sticky = m_sticky | evv;
      if (evv != 0 && !m_fv) begin
         m_fv  = 1'b1;
         m_fts = ts_pre;
         m_fch = -1;
         for (int i = 0; i < NB_CH; i++) begin
            if (evv[i] && m_fch < 0) m_fch = i;
         end
      end
      thr_eff = (threshold_i == 0) ? 1 : int'(threshold_i);
      if (m_state == 2 && ack_i) begin
         m_cnt   = 0;
         m_state = 1;
      end else if (evv != 0) begin
         m_cnt = sat_add1(m_cnt, CNT_MAX);
         if (m_state == 1 && m_cnt >= thr_eff) m_state = 2;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state"},  32'(state_o),        32'(m_state));
      check({tag, ".alarm"},  32'(alarm_o),        32'(m_state == 2));
      check({tag, ".sticky"}, 32'(fault_sticky_o), 32'(m_sticky));
      check({tag, ".cnt"},    32'(fault_cnt_o),    32'(m_cnt));
      check({tag, ".fvalid"}, 32'(first_valid_o),  32'(m_fv));
      check({tag, ".fch"},    32'(first_ch_o),     32'(m_fch));
      check({tag, ".fts"},    32'(first_ts_o),     32'(m_fts));
   endtask

   // Driver: apply current inputs across one edge, then compare.
   task automatic tick(input string tag);
      model_step();
      @(posedge clk_i);
      #1;
      check_all(tag);
   endtask

   task automatic set_idle();
      clear_i = 1'b0;
      ack_i   = 1'b0;
      fault_i = '0;
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst_ni      = 1'b0;
      clear_i     = 1'b0;
      enable_i    = 1'b0;
      ch_mask_i   = '0;
      threshold_i = '0;
      fault_i     = '0;
      ack_i       = 1'b0;
      model_reset();

      // Reset state.
      repeat (2) @(posedge clk_i);
      #1;
      check_all("reset");
      rst_ni = 1'b1;

      // Pulses on channel 2 at timestamps 5, 9 and 12 with threshold 3.
      enable_i    = 1'b1;
      threshold_i = 8'd3;
      for (int c = 0; c < 16; c++) begin
         fault_i = (m_state != 0 && (m_ts == 5 || m_ts == 9 || m_ts == 12)) ? 4'b0100 : 4'b0000;
         tick("tp1");
      end
      fault_i = '0;
      check("tp1_state", 32'(state_o), 32'd2);
      check("tp1_alarm", 32'(alarm_o), 32'd1);
      check("tp1_cnt",   32'(fault_cnt_o), 32'd3);
      check("tp1_fch",   32'(first_ch_o), 32'd2);
      check("tp1_fts",   32'(first_ts_o), 32'd5);

      // Masked channel in a multi-channel fault.
      clear_i = 1'b1;
      tick("tp2_clr");
      set_idle();
      fault_i   = 4'b1010;
      ch_mask_i = 4'b0010;
      tick("tp2");
      check("tp2_fch",    32'(first_ch_o), 32'd3);
      check("tp2_sticky", 32'(fault_sticky_o), 32'b1000);
      check("tp2_cnt",    32'(fault_cnt_o), 32'd1);

      // Trip, then acknowledge together with a new fault.
      ch_mask_i   = '0;
      threshold_i = 8'd1;
      fault_i     = 4'b0100;
      tick("tp3_trip");
      check("tp3_tripped", 32'(state_o), 32'd2);
      fault_i = 4'b0001;
      ack_i   = 1'b1;
      tick("tp3_ack");
      set_idle();
      check("tp3_state",  32'(state_o), 32'd1);
      check("tp3_alarm",  32'(alarm_o), 32'd0);
      check("tp3_cnt",    32'(fault_cnt_o), 32'd0);
      check("tp3_sticky", 32'(fault_sticky_o), 32'b1101);
      check("tp3_fch",    32'(first_ch_o), 32'd3);

      // Threshold 0 trips on one event; long run saturates the counter.
      clear_i = 1'b1;
      tick("tp4_clr");
      set_idle();
      threshold_i = 8'd0;
      fault_i     = 4'b0010;
      tick("tp4_one");
      check("tp4_alarm", 32'(alarm_o), 32'd1);
      fault_i = '0;
      ack_i   = 1'b1;
      tick("tp4_ack");
      ack_i   = 1'b0;
      fault_i = 4'b0010;
      for (int c = 0; c < 300; c++) tick("tp4_run");
      check("tp4_sat", 32'(fault_cnt_o), 32'd255);

      // Disable freezes everything but drops the alarm.
      enable_i = 1'b0;
      fault_i  = 4'b1111;
      for (int c = 0; c < 5; c++) tick("tp5_dis");
      check("tp5_state",  32'(state_o), 32'd0);
      check("tp5_cnt",    32'(fault_cnt_o), 32'd255);
      check("tp5_sticky", 32'(fault_sticky_o), 32'b0010);
      check("tp5_alarm",  32'(alarm_o), 32'd0);
      fault_i  = '0;
      enable_i = 1'b1;
      clear_i  = 1'b1;
      tick("tp5_clr");
      check("tp5_clr_state", 32'(state_o), 32'd1);
      check("tp5_clr_cnt",   32'(fault_cnt_o), 32'd0);
      clear_i = 1'b0;
      fault_i = 4'b0001;
      tick("tp5_ts0");
      fault_i = '0;
      check("tp5_fts0", 32'(first_ts_o), 32'd0);

      // Timestamp saturation.
      threshold_i = 8'd200;
      clear_i     = 1'b1;
      tick("ts_clr");
      clear_i = 1'b0;
      for (int c = 0; c < 1100; c++) tick("ts_run");
      fault_i = 4'b0100;
      tick("ts_hit");
      fault_i = '0;
      check("ts_sat", 32'(first_ts_o), 32'(TS_MAX));

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         enable_i    = ($urandom_range(0, 19) != 0);
         clear_i     = ($urandom_range(0, 49) == 0);
         ack_i       = ($urandom_range(0, 3) == 0);
         fault_i     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         if ($urandom_range(0, 7) == 0) ch_mask_i = 4'($urandom);
         if ($urandom_range(0, 15) == 0) threshold_i = 8'($urandom_range(0, 6));
         tick("rnd");
      end
      set_idle();

      // Asynchronous reset between edges while tripped.
      enable_i    = 1'b1;
      threshold_i = 8'd1;
      ch_mask_i   = '0;
      clear_i     = 1'b1;
      tick("ar_clr");
      clear_i = 1'b0;
      fault_i = 4'b0001;
      tick("ar_trip");
      fault_i = '0;
      check("ar_tripped", 32'(state_o), 32'd2);
      #3;
      rst_ni = 1'b0;
      #1;
      model_reset();
      check_all("ar_async");
      check("ar_state", 32'(state_o), 32'd0);
      check("ar_alarm", 32'(alarm_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      for (int c = 0; c < 4; c++) tick("ar_post");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
